// File: rtl/sonar_arbiter_if.sv
// sonar_arbiter_if: request/ack/result bundle shared by the two ranger clients
// and the sensor pins. The master side drives requests and the raw echo; the
// slave side is the arbiter.
interface sonar_arbiter_if;
  logic        req0;
  logic        req1;
  logic        ack0;
  logic        ack1;
  logic        valid0;
  logic        valid1;
  logic [31:0] distance;
  logic        timeout;
  logic        busy;
  logic        sonar_trig;
  logic        sonar_echo;

  modport master (
    output req0, req1, sonar_echo,
    input  ack0, ack1, valid0, valid1, distance, timeout, busy, sonar_trig
  );

  modport slave (
    input  req0, req1, sonar_echo,
    output ack0, ack1, valid0, valid1, distance, timeout, busy, sonar_trig
  );
endinterface

// File: rtl/sonar_arbiter.sv
// sonar_arbiter: two-port round-robin front end for a single HC-SR04-style
// ranger. It generates the trigger pulse, times the synchronised echo and
// returns the result only to the port that won the grant. After each
// measurement it enforces a quiet hold-off before the next trigger.
//
// Optional build macro SONAR_CM_EN: the result is converted to centimetres
// ((cycles * 23) >> 16 at 50 MHz). This costs one extra register stage in
// REPORT. When the macro is undefined, distance is raw clock cycles and no
// multiplier is built.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrate between req0/req1, pointer breaks ties
// TRIG      | sonar_trig high for TRIG_CYCLES, ack on the last high cycle
// WAIT_RISE | trigger released, waiting for the synced echo to rise
// MEASURE   | counting synced-echo-high cycles
// REPORT    | drive validN with distance/timeout to the owner
// HOLDOFF   | quiet time of HOLDOFF_CYCLES before returning to IDLE
module sonar_arbiter #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned ECHO_TIMEOUT   = 1900000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
  input logic            clk,
  input logic            rst,
  sonar_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  // The shared timer is a down-counter. Each phase loads it with its length
  // minus one, and the phase ends when it reaches zero.
  localparam logic [31:0] TRIG_LOAD  = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] ECHO_LOAD  = 32'(ECHO_TIMEOUT - 1);
  localparam logic [31:0] HOLD_LOAD  = 32'(HOLDOFF_CYCLES - 1);
  // A one-cycle trigger puts the ack on the same cycle as the grant.
  localparam logic        TRIG_SHORT = (TRIG_CYCLES <= 1);

  state_t      state;
  logic        owner;
  logic        prio;
  logic [31:0] tmr;
  logic [31:0] echo_cnt;
  logic        echo_meta;
  logic        echo_sync;

  logic        ack0_q;
  logic        ack1_q;
  logic        valid0_q;
  logic        valid1_q;
  logic [31:0] dist_q;
  logic        timeout_q;
  logic        busy_q;
  logic        trig_q;

  logic        grant_any;
  logic        grant_port;
  logic        tmr_tc;
  logic        meas_done;
  logic        meas_to;

`ifdef SONAR_CM_EN
  logic        cm_stage;
  logic [31:0] cm_cnt;
  logic        cm_to;
  logic [31:0] cm_dist;
`endif

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.valid0     = valid0_q;
  assign bus.valid1     = valid1_q;
  assign bus.distance   = dist_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;
  assign bus.sonar_trig = trig_q;

  assign tmr_tc = (tmr == 32'd0);

  // Two-flop synchroniser for the asynchronous echo pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= bus.sonar_echo;
      echo_sync <= echo_meta;
    end
  end

  // Round-robin pick: a lone requester wins, on a tie the pointer decides
  always_comb begin
    grant_any  = bus.req0 | bus.req1;
    grant_port = (bus.req0 & bus.req1) ? prio : bus.req1;
  end

  // End-of-measurement detect. An echo fall on the timeout cycle still
  // counts as a normal reading, because the fall is checked first.
  always_comb begin
    meas_done = 1'b0;
    meas_to   = 1'b0;
    if (state == WAIT_RISE) begin
      if (tmr_tc) begin
        meas_done = 1'b1;
        meas_to   = 1'b1;
      end
    end else if (state == MEASURE) begin
      if (!echo_sync) begin
        meas_done = 1'b1;
      end else if (tmr_tc) begin
        meas_done = 1'b1;
        meas_to   = 1'b1;
      end
    end
  end

`ifdef SONAR_CM_EN
  // Cycles to centimetres at 50 MHz; the full product is kept before the shift
  always_comb begin
    cm_dist = 32'((64'(cm_cnt) * 64'd23) >> 16);
  end
`endif

  // Main sequencer: grant, trigger timing, echo timing, result hand-off, hold-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prio      <= 1'b0;
      tmr       <= '0;
      echo_cnt  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      dist_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      trig_q    <= 1'b0;
`ifdef SONAR_CM_EN
      cm_stage  <= 1'b0;
      cm_cnt    <= '0;
      cm_to     <= 1'b0;
`endif
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner  <= grant_port;
            prio   <= ~grant_port;
            tmr    <= TRIG_LOAD;
            trig_q <= 1'b1;
            busy_q <= 1'b1;
            ack0_q <= TRIG_SHORT & ~grant_port;
            ack1_q <= TRIG_SHORT & grant_port;
            state  <= TRIG;
          end
        end

        TRIG: begin
          if (tmr_tc) begin
            trig_q   <= 1'b0;
            tmr      <= ECHO_LOAD;
            echo_cnt <= '0;
            state    <= WAIT_RISE;
          end else begin
            tmr <= tmr - 32'd1;
            if (tmr == 32'd1) begin
              ack0_q <= ~owner;
              ack1_q <= owner;
            end
          end
        end

        WAIT_RISE, MEASURE: begin
          if (meas_done) begin
            state <= REPORT;
`ifdef SONAR_CM_EN
            cm_stage <= 1'b1;
            cm_cnt   <= echo_cnt;
            cm_to    <= meas_to;
`else
            dist_q    <= meas_to ? '1 : echo_cnt;
            timeout_q <= meas_to;
            valid0_q  <= ~owner;
            valid1_q  <= owner;
`endif
          end else begin
            tmr <= tmr - 32'd1;
            if (state == WAIT_RISE) begin
              if (echo_sync) begin
                echo_cnt <= 32'd1;
                state    <= MEASURE;
              end
            end else if (echo_cnt != '1) begin
              echo_cnt <= echo_cnt + 32'd1;
            end
          end
        end

        REPORT: begin
`ifdef SONAR_CM_EN
          if (cm_stage) begin
            cm_stage  <= 1'b0;
            dist_q    <= cm_to ? '1 : cm_dist;
            timeout_q <= cm_to;
            valid0_q  <= ~owner;
            valid1_q  <= owner;
          end else begin
            tmr   <= HOLD_LOAD;
            state <= HOLDOFF;
          end
`else
          tmr   <= HOLD_LOAD;
          state <= HOLDOFF;
`endif
        end

        HOLDOFF: begin
          if (tmr_tc) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end

        default: begin
          trig_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_arbiter.sv
// tb_sonar_arbiter: directed and random transactions against sonar_arbiter.
// The expected results come from the timing rules: a grant at cycle g makes
// the trigger fall at f = g + T + 1, and a synced echo fall at cycle m makes
// valid appear at m + 1. A timeout makes valid appear at f + ET.
module tb_sonar_arbiter;
  localparam int T  = 4;
  localparam int H  = 10;
`ifdef SONAR_CM_EN
  localparam int ET = 8000;
  localparam int XR = 1;
`else
  localparam int ET = 100;
  localparam int XR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   ptr;
  bit   r0;
  bit   r1;
  int   nval;
  int   g;
  int   f;

  sonar_arbiter_if bus();

  sonar_arbiter #(
    .TRIG_CYCLES(T),
    .ECHO_TIMEOUT(ET),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone requester wins; on a tie the pointer port wins.
  function automatic bit pick(input bit a, input bit b, input bit p);
    if (a && b) return p;
    return b;
  endfunction

  function automatic logic [31:0] scale(input int n);
`ifdef SONAR_CM_EN
    return 32'((longint'(n) * 23) >>> 16);
`else
    return 32'(n);
`endif
  endfunction

  task automatic raise(input bit a, input bit b);
    if (a) begin bus.req0 = 1'b1; r0 = 1'b1; end
    if (b) begin bus.req1 = 1'b1; r1 = 1'b1; end
  endtask

  // Run one grant-to-rearm transaction for port p, starting in IDLE now.
  // The raw echo is high from f+d for w cycles (d >= -2; w == 0 means no echo).
  task automatic serve(input string tag, input bit p, input int d, input int w);
    int gg, ff, m, lim, v;
    int rise, trig_hi, ack_n, ack_at, ack_oth, val_n, val_at, val_oth;
    logic        to_exp;
    logic        to_obs;
    logic [31:0] dist_exp;
    logic [31:0] dist_obs;
    gg  = cyc;
    ff  = gg + T + 1;
    m   = ff + d + w + 2;
    lim = ff + ET - 1;
    if (w > 0 && m <= lim) begin
      to_exp = 1'b0; dist_exp = scale(w); v = m + 1 + XR;
    end else begin
      to_exp = 1'b1; dist_exp = '1; v = ff + ET + XR;
    end
    rise = -1; trig_hi = 0; ack_n = 0; ack_at = -1; ack_oth = 0;
    val_n = 0; val_at = -1; val_oth = 0; dist_obs = '0; to_obs = 1'b0;
    chk({tag, " idle at start"}, 32'(bus.busy), 32'd0);
    while (cyc <= v + H) begin
      bus.sonar_echo = (cyc >= ff + d) && (cyc < ff + d + w);
      if (bus.sonar_trig) begin
        trig_hi++;
        if (rise < 0) rise = cyc;
      end
      if (p ? bus.ack1 : bus.ack0) begin
        ack_n++; ack_at = cyc;
        if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (p ? bus.ack0 : bus.ack1) ack_oth++;
      if (p ? bus.valid1 : bus.valid0) begin
        val_n++; val_at = cyc; dist_obs = bus.distance; to_obs = bus.timeout;
      end
      if (p ? bus.valid0 : bus.valid1) val_oth++;
      if (cyc == v + H) chk({tag, " busy end of holdoff"}, 32'(bus.busy), 32'd1);
      step();
    end
    bus.sonar_echo = 1'b0;
    chk({tag, " trig rise cycle"}, 32'(rise), 32'(gg + 1));
    chk({tag, " trig high cycles"}, 32'(trig_hi), 32'(T));
    chk({tag, " ack count"}, 32'(ack_n), 32'd1);
    chk({tag, " ack cycle"}, 32'(ack_at), 32'(gg + T));
    chk({tag, " other ack"}, 32'(ack_oth), 32'd0);
    chk({tag, " valid count"}, 32'(val_n), 32'd1);
    chk({tag, " valid cycle"}, 32'(val_at), 32'(v));
    chk({tag, " other valid"}, 32'(val_oth), 32'd0);
    chk({tag, " distance"}, dist_obs, dist_exp);
    chk({tag, " timeout"}, 32'(to_obs), 32'(to_exp));
  endtask

  task automatic txn(input string tag, input int d, input int w);
    bit p;
    p   = pick(r0, r1, ptr);
    ptr = !p;
    if (p) r1 = 1'b0; else r0 = 1'b0;
    serve(tag, p, d, w);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.sonar_echo = 1'b0;
    ptr = 1'b0; r0 = 1'b0; r1 = 1'b0;
    step(); step(); step();
    chk("reset trig", 32'(bus.sonar_trig), 32'd0);
    chk("reset ack0", 32'(bus.ack0), 32'd0);
    chk("reset ack1", 32'(bus.ack1), 32'd0);
    chk("reset valid0", 32'(bus.valid0), 32'd0);
    chk("reset valid1", 32'(bus.valid1), 32'd0);
    chk("reset distance", bus.distance, 32'd0);
    chk("reset timeout", 32'(bus.timeout), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();

    // contention from reset, then again once the pointer has come back
    raise(1'b1, 1'b1);
    txn("contend1 a", 3, 37);
    txn("contend1 b", 5, 20);
    raise(1'b1, 1'b1);
    txn("contend2 a", 1, 9);
    txn("contend2 b", 2, 14);

    raise(1'b1, 1'b0);
    txn("single req0", 0, 37);
`ifdef SONAR_CM_EN
    raise(1'b1, 1'b0);
    txn("cm echo 5800", 0, 5800);
`endif
    raise(1'b0, 1'b1);
    txn("timeout no echo", 0, 0);
    raise(1'b1, 1'b0);
    txn("long echo", 48, ET + 50);
    raise(1'b0, 1'b1);
    txn("fall at limit", 10, ET - 13);
    raise(1'b1, 1'b0);
    txn("fall past limit", 10, ET - 12);
    raise(1'b1, 1'b0);
    txn("echo high on entry", -2, 20);

    // asynchronous reset in the middle of a measurement
    g = cyc;
    f = g + T + 1;
    raise(1'b1, 1'b0);
    while (cyc < f + 10) begin
      bus.sonar_echo = (cyc >= f);
      if (bus.ack0) begin bus.req0 = 1'b0; r0 = 1'b0; end
      step();
    end
    chk("rst-measure busy before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst-measure busy", 32'(bus.busy), 32'd0);
    chk("rst-measure trig", 32'(bus.sonar_trig), 32'd0);
    chk("rst-measure distance", bus.distance, 32'd0);
    ptr = 1'b0;
    nval = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (i == 3) rst = 1'b0;
      if (i == 8) bus.sonar_echo = 1'b0;
      if (bus.valid0 | bus.valid1) nval++;
    end
    chk("rst-measure no valid", 32'(nval), 32'd0);
    raise(1'b1, 1'b0);
    txn("after reset req0", 1, 12);

    // reset while the trigger is high; the pointer must return to port 0
    raise(1'b1, 1'b0);
    step(); step();
    chk("rst-trig trig before", 32'(bus.sonar_trig), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst-trig trig", 32'(bus.sonar_trig), 32'd0);
    chk("rst-trig busy", 32'(bus.busy), 32'd0);
    bus.req0 = 1'b0; r0 = 1'b0; ptr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    raise(1'b1, 1'b1);
    txn("post-rst pair a", 4, 25);
    txn("post-rst pair b", 0, 6);

    for (int i = 0; i < 8; i++) begin
      bit a;
      bit b;
      int d;
      int w;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (!a && !b && !r0 && !r1) a = 1'b1;
      raise(a, b);
      d = int'($urandom_range(0, 30));
      w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 90));
      txn($sformatf("rand%0d", i), d, w);
    end
    for (int i = 0; i < 2; i++) begin
      if (r0 || r1) txn("drain", 2, 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonar_arbiter.md
# sonar_arbiter

Shared front-end for the single HC-SR04-style ultrasonic ranger on the cutting rig. Two requesters need the sensor: the cutting sequencer (port 0) and the blade-guard safety monitor (port 1). The block arbitrates between them round-robin and generates the timed trigger pulse. It synchronises and times the echo, then returns a distance result to the granted requester only. It also enforces the sensor's minimum re-ping interval.

## Interface
- TRIG_CYCLES, 500: sonar_trig high time (10 µs at 50 MHz).
- ECHO_TIMEOUT, 1900000: max cycles from trigger fall to echo fall (38 ms).
- HOLDOFF_CYCLES, 3000000: quiet cycles after a measurement before the next trigger (60 ms).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  level requests; held until the matching ack.
- ack0, ack1  out  1  one-cycle pulse when that port's trigger pulse completes.
- valid0, valid1  out  1  one-cycle pulse; distance/timeout valid for that port.
- distance  out  32  echo high time in clk cycles (shared bus, qualified by validN).
- timeout  out  1  high with validN when no complete echo arrived.
- busy  out  1  high in every state except IDLE.
- sonar_trig  out  1  to sensor trigger pin, registered.
- sonar_echo  in  1  from sensor echo pin, asynchronous; two-flop synchroniser inside.

## Operation
- States:
  - IDLE: arbitrate.
  - TRIG: sonar_trig high, counter runs to TRIG_CYCLES.
  - WAIT_RISE: wait for synced echo high.
  - MEASURE: count while echo high.
  - REPORT: drive validN.
  - HOLDOFF: count to HOLDOFF_CYCLES, then IDLE.
- Arbitration happens only in IDLE. Only one requester high: it wins. Both high: the port named by the priority pointer wins, then the pointer moves to the other port. After reset the pointer favours port 0.
- The granted port is latched as owner. Requests are ignored from grant until the return to IDLE. A request dropped before grant has no effect.
- Timeout counter starts at the trigger fall and covers WAIT_RISE plus MEASURE.
- Reaching ECHO_TIMEOUT in either state goes to REPORT with distance = 32'hFFFFFFFF and timeout = 1.
- Normal echo: distance = count of synced-echo-high cycles, timeout = 0.
- The echo counter saturates at all-ones and never wraps.
- Echo already high on entry to WAIT_RISE: counting starts immediately.
- An echo fall in the same cycle the timeout is reached counts as a normal measurement; the echo takes precedence.
- distance holds its last value between reports.
- Reset mid-operation: everything returns to reset values immediately, including sonar_trig low. No ack or valid is emitted for the aborted measurement.

## Timing
- Reset values: sonar_trig 0, ack0/1 0, valid0/1 0, distance 0, timeout 0, busy 0, pointer to port 0, state IDLE.
- Trigger: reqN sampled high in IDLE at cycle N gives sonar_trig high from N+1 through N+TRIG_CYCLES. ackN pulses at N+TRIG_CYCLES, the last high cycle.
- Echo latency: two cycles of synchroniser delay.
- Result: synced echo fall seen at cycle M gives validN at M+1.
- Re-arm: HOLDOFF lasts exactly HOLDOFF_CYCLES cycles; IDLE can grant in the following cycle.
- The sequencer's level-trigger / wait-ack / wait-valid protocol works unchanged against port 0.

## Configuration
- SONAR_CM_EN defined:
  - REPORT takes one extra registered cycle, so validN comes at M+2.
  - distance = (cycles × 23) >> 16, i.e. centimetres at 50 MHz.
  - Timeout still reports all-ones.
- Not defined: distance is raw cycles, valid at M+1, and no multiplier is built.

## Test plan
Bench parameters: TRIG_CYCLES=4, ECHO_TIMEOUT=100, HOLDOFF_CYCLES=10.
- **Single request:** req0 high, echo high for 37 cycles → sonar_trig high exactly 4 cycles, one ack0 pulse, valid0 with distance=37 and timeout=0, valid1 never.
- **Contention:** req0 and req1 both high from reset → port 0 served first, then port 1 after 10 holdoff cycles. On the next simultaneous pair, port 0 wins again because the pointer has returned.
- **Timeout:** req1 with echo never rising → valid1 exactly 100 cycles after the trigger fall, distance=FFFFFFFF, timeout=1.
- **Long echo:** echo rises at cycle 50, stays high → timeout at 100 and a timeout report. Separately, echo falling exactly at the limit → normal report.
- **Async reset:** rst asserted mid-MEASURE → sonar_trig/busy 0 immediately, no valid; a new req0 after release gets a fresh 4-cycle trigger.
- **SONAR_CM_EN:** echo 5800 cycles (bench ECHO_TIMEOUT raised) → distance=2, valid0 two cycles after the echo fall.
